trng_fifo_reader: RTL

TRNG_FIFO_READER -- requirements
Module: trng_fifo_reader

---
 rtl/trng_fifo_reader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/trng_fifo_reader.sv
// TRNG byte collector: warm-up discard FSM feeding a show-ahead FIFO with sticky overflow flag.
// Optional repetition-count health test is compiled in when TRNG_HEALTH_TEST_EN is defined.
module trng_fifo_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int DISCARD_BYTES = 4,
  parameter int RCT_CUTOFF    = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enable_i,
  input  logic                     clr_i,
  input  logic                     rnd_valid_i,
  input  logic [DATA_WIDTH-1:0]    rnd_data_i,
  input  logic                     rd_en_i,
  output logic [DATA_WIDTH-1:0]    rd_data_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic                     health_fail_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DISCARD_BYTES + 1) + 1;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [DW-1:0] DISC_MAX = DW'(DISCARD_BYTES);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_e;

  state_e                state_q, state_d;
  logic [DW-1:0]         disc_q, disc_d;
  logic                  in_run;
  logic                  health_ok;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  empty, full, pop, push_try, push;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      disc_q  <= disc_d;
    end
  end

  // Warm-up exits on the same pulse that completes the discard count, so back-to-back bytes are not lost.
  always_comb begin
    state_d = state_q;
    disc_d  = disc_q;
    if (!enable_i) begin
      state_d = IDLE;
      disc_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WARMUP;
          disc_d  = '0;
        end
        WARMUP: begin
          if (disc_q == DISC_MAX) begin
            state_d = RUN;
          end else if (rnd_valid_i) begin
            disc_d = disc_q + 1'b1;
            if (disc_d == DISC_MAX) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    in_run = (state_q == RUN);
  end

`ifdef TRNG_HEALTH_TEST_EN
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam logic [RW-1:0] CUT = RW'(RCT_CUTOFF);

  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [RW-1:0]         rep_q, rep_d, rep_next;
  logic                  fail_q, fail_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q <= '0;
      rep_q  <= '0;
      fail_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      rep_q  <= rep_d;
      fail_q <= fail_d;
    end
  end

  // A zero run count means no previous RUN byte yet, so a first byte of 0 never matches.
  always_comb begin
    prev_d    = prev_q;
    rep_d     = rep_q;
    fail_d    = fail_q;
    rep_next  = (rep_q != '0 && rnd_data_i == prev_q) ? rep_q + 1'b1 : RW'(1);
    health_ok = !fail_q && (rep_next != CUT);
    if (clr_i) begin
      prev_d = '0;
      rep_d  = '0;
      fail_d = 1'b0;
    end else if (!in_run) begin
      prev_d = '0;
      rep_d  = '0;
    end else if (rnd_valid_i && !fail_q) begin
      prev_d = rnd_data_i;
      rep_d  = rep_next;
      if (rep_next == CUT) fail_d = 1'b1;
    end
  end

  assign health_fail_o = fail_q;
`else
  assign health_ok     = 1'b1;
  assign health_fail_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == FULL_LVL);
    pop      = rd_en_i && !empty;
    push_try = in_run && rnd_valid_i && health_ok;
    push     = push_try && (!full || pop);
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_q] = rnd_data_i;
        wr_d        = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
      if (push_try && full && !pop) ovf_d = 1'b1;
    end
  end

  // Head is masked while empty so stale memory never leaks out after reset or a flush.
  assign rd_data_o  = empty ? '0 : mem_q[rd_q];
  assign rd_valid_o = !empty;
  assign level_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule
